msx_slot_io_responder: RTL and testbench

- Cartridge-side responder for MSX Z80 slot I/O cycles.
- Samples the asynchronous slot strobes in the 85.909 MHz `clk` domain and decodes VDP ports 0x98–0x9B.
- Turns each qualified /IORQ+/WR or /IORQ+/RD cycle into exactly one valid/ready transaction on the internal VDP register bus.
- Drives read data, data-bus direction and WAIT back to the slot. Sits between the top-level slot pins and the VDP core.

---
 rtl/msx_slot_io_responder.sv | 196 +++++++++++++++++++
 tb/tb_msx_slot_io_responder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msx_slot_io_responder.sv
// MSX cartridge-side I/O responder: filters the asynchronous Z80 slot strobes,
// decodes the VDP port window and bridges each slot cycle onto a valid/ready bus.
module msx_slot_io_responder #(
  parameter logic [7:0]  IO_BASE       = 8'h98,
  parameter logic [7:0]  IO_MASK       = 8'hFC,
  parameter int unsigned FILTER_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] slot_a,
  input  logic       slot_iorq_n,
  input  logic       slot_rd_n,
  input  logic       slot_wr_n,
  input  logic [7:0] slot_d_in,
  output logic [7:0] slot_d_out,
  output logic       slot_d_oe,
  output logic       slot_wait,
  output logic       bus_valid,
  input  logic       bus_ready,
  output logic       bus_write,
  output logic [1:0] bus_address,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_rdata_en
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RD_WAIT,
    HOLD
  } state_t;

  localparam int          IORQ       = 2;
  localparam int          RD         = 1;
  localparam int          WR         = 0;
  localparam logic [2:0]  CNT_THRESH = 3'(FILTER_CYCLES);
  localparam logic [2:0]  CNT_MAX    = 3'd7;

  // Strobes packed as {iorq_n, rd_n, wr_n}.
  logic [2:0]      strobe_meta;
  logic [2:0]      strobe_sync;
  logic [2:0][2:0] low_cnt;

  logic iorq_lo;
  logic rd_lo;
  logic wr_lo;
  logic iorq_high;
  logic addr_match;
  logic hit;

  state_t     state;
  state_t     state_nxt;
  logic       aborted;
  logic       aborted_nxt;
  logic       valid_nxt;
  logic       wait_nxt;
  logic       oe_nxt;
  logic [7:0] dout_nxt;
  logic       write_nxt;
  logic [1:0] addr_nxt;
  logic [7:0] wdata_nxt;

  // NOTE: synchronizers reset to 1 so an inactive (high) strobe is assumed
  // until real samples arrive; resetting to 0 would fake a low cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      strobe_meta <= '1;
      strobe_sync <= '1;
      low_cnt     <= '0;
    end else begin
      strobe_meta <= {slot_iorq_n, slot_rd_n, slot_wr_n};
      strobe_sync <= strobe_meta;
      for (int i = 0; i < 3; i++) begin
        if (strobe_sync[i]) begin
          low_cnt[i] <= '0;
        end else if (low_cnt[i] != CNT_MAX) begin
          low_cnt[i] <= low_cnt[i] + 3'd1;
        end
      end
    end
  end

  assign iorq_lo    = (low_cnt[IORQ] >= CNT_THRESH);
  assign rd_lo      = (low_cnt[RD]   >= CNT_THRESH);
  assign wr_lo      = (low_cnt[WR]   >= CNT_THRESH);
  // Cycle end is taken from a single synchronized high sample, unfiltered.
  assign iorq_high  = strobe_sync[IORQ];
  assign addr_match = ((slot_a & IO_MASK) == IO_BASE);
  assign hit        = iorq_lo & (rd_lo | wr_lo) & addr_match;

  // NOTE: every output of this block gets a default from its current register
  // value before the case, so no path can leave a signal unassigned (no latch).
  always_comb begin
    state_nxt   = state;
    aborted_nxt = aborted;
    valid_nxt   = bus_valid;
    wait_nxt    = slot_wait;
    oe_nxt      = slot_d_oe;
    dout_nxt    = slot_d_out;
    write_nxt   = bus_write;
    addr_nxt    = bus_address;
    wdata_nxt   = bus_wdata;

    unique case (state)
      IDLE: begin
        aborted_nxt = 1'b0;
        oe_nxt      = 1'b0;
        if (hit) begin
          write_nxt = wr_lo;
          addr_nxt  = slot_a[1:0];
          wdata_nxt = slot_d_in;
          valid_nxt = 1'b1;
          wait_nxt  = 1'b1;
          state_nxt = REQ;
        end
      end

      REQ: begin
        // A released slot cycle still finishes its handshake; it just skips HOLD.
        if (iorq_high) begin
          aborted_nxt = 1'b1;
        end
        if (bus_ready) begin
          valid_nxt = 1'b0;
          if (aborted_nxt) begin
            wait_nxt  = 1'b0;
            state_nxt = IDLE;
          end else if (bus_write) begin
            wait_nxt  = 1'b0;
            state_nxt = HOLD;
          end else if (bus_rdata_en) begin
            dout_nxt  = bus_rdata;
            wait_nxt  = 1'b0;
            oe_nxt    = rd_lo;
            state_nxt = HOLD;
          end else begin
            state_nxt = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        if (iorq_high) begin
          wait_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (bus_rdata_en) begin
          dout_nxt  = bus_rdata;
          wait_nxt  = 1'b0;
          oe_nxt    = rd_lo;
          state_nxt = HOLD;
        end
      end

      HOLD: begin
        if (iorq_high) begin
          oe_nxt    = 1'b0;
          state_nxt = IDLE;
        end else begin
          oe_nxt = ~bus_write & rd_lo;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      aborted     <= 1'b0;
      bus_valid   <= 1'b0;
      slot_wait   <= 1'b0;
      slot_d_oe   <= 1'b0;
      slot_d_out  <= 8'h00;
      bus_write   <= 1'b0;
      bus_address <= 2'b00;
      bus_wdata   <= 8'h00;
    end else begin
      state       <= state_nxt;
      aborted     <= aborted_nxt;
      bus_valid   <= valid_nxt;
      slot_wait   <= wait_nxt;
      slot_d_oe   <= oe_nxt;
      slot_d_out  <= dout_nxt;
      bus_write   <= write_nxt;
      bus_address <= addr_nxt;
      bus_wdata   <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_msx_slot_io_responder.sv
// Bench for msx_slot_io_responder: Z80-like slot cycles against a VDP responder
// model, with a transaction scoreboard and slot-side timing expectations.
`timescale 1ns/1ps
module tb_msx_slot_io_responder;

  typedef struct packed {
    logic       wr;
    logic [1:0] adr;
    logic [7:0] data;
  } txn_t;

  logic       clk;
  logic       reset_n;
  logic [7:0] slot_a;
  logic       slot_iorq_n;
  logic       slot_rd_n;
  logic       slot_wr_n;
  logic [7:0] slot_d_in;
  logic [7:0] slot_d_out;
  logic       slot_d_oe;
  logic       slot_wait;
  logic       bus_valid;
  logic       bus_ready;
  logic       bus_write;
  logic [1:0] bus_address;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_rdata_en;

  int n_checks = 0;
  int n_errors = 0;

  txn_t exp_q[$];
  txn_t got_q[$];

  int         ready_lat = 0;
  int         rdata_lat = 1;
  logic [7:0] vdp_rdata = 8'h00;
  int         valid_age = 0;
  int         rd_pend   = -1;
  int         hs_count  = 0;
  int         hs_len    = 0;
  bit         pay_changed  = 1'b0;
  bit         wait_dropped = 1'b0;
  txn_t       prev_pay;

  msx_slot_io_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .slot_a       (slot_a),
    .slot_iorq_n  (slot_iorq_n),
    .slot_rd_n    (slot_rd_n),
    .slot_wr_n    (slot_wr_n),
    .slot_d_in    (slot_d_in),
    .slot_d_out   (slot_d_out),
    .slot_d_oe    (slot_d_oe),
    .slot_wait    (slot_wait),
    .bus_valid    (bus_valid),
    .bus_ready    (bus_ready),
    .bus_write    (bus_write),
    .bus_address  (bus_address),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_rdata_en (bus_rdata_en)
  );

  initial begin
    clk = 1'b0;
    forever #6 clk = ~clk;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // VDP model: ready after ready_lat cycles of valid, read data rdata_lat after ready.
  initial begin
    bus_ready    = 1'b0;
    bus_rdata_en = 1'b0;
    bus_rdata    = 8'h00;
    prev_pay     = '0;
    forever begin
      @(negedge clk);
      #1;
      bus_ready    = 1'b0;
      bus_rdata_en = 1'b0;
      if (!reset_n) begin
        valid_age = 0;
        rd_pend   = -1;
      end else begin
        if (rd_pend > 0) begin
          rd_pend--;
          if (rd_pend == 0) begin
            bus_rdata_en = 1'b1;
            rd_pend      = -1;
          end
        end
        if (bus_valid) begin
          if (valid_age > 0 && (txn_t'({bus_write, bus_address, bus_wdata}) !== prev_pay))
            pay_changed = 1'b1;
          if (!slot_wait) wait_dropped = 1'b1;
          prev_pay = {bus_write, bus_address, bus_wdata};
          if (valid_age >= ready_lat) begin
            bus_ready = 1'b1;
            got_q.push_back(prev_pay);
            hs_len = valid_age + 1;
            hs_count++;
            valid_age = 0;
            if (!bus_write) begin
              bus_rdata = vdp_rdata;
              if (rdata_lat == 0) bus_rdata_en = 1'b1;
              else rd_pend = rdata_lat;
            end
          end else begin
            valid_age++;
          end
        end else begin
          valid_age = 0;
        end
      end
    end
  end

  task automatic check_scoreboard(input string tag);
    txn_t e;
    txn_t g;
    check({tag, "_txn_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, "_txn_payload"}, 32'(g), 32'(e));
    end
    exp_q.delete();
    got_q.delete();
    check({tag, "_payload_stable"}, 32'(pay_changed), 32'd0);
    check({tag, "_wait_during_valid"}, 32'(wait_dropped), 32'd0);
    pay_changed  = 1'b0;
    wait_dropped = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_d_out"}, 32'(slot_d_out), 32'h00);
    check({tag, "_d_oe"}, 32'(slot_d_oe), 32'd0);
    check({tag, "_wait"}, 32'(slot_wait), 32'd0);
    check({tag, "_valid"}, 32'(bus_valid), 32'd0);
    check({tag, "_write"}, 32'(bus_write), 32'd0);
    check({tag, "_address"}, 32'(bus_address), 32'd0);
    check({tag, "_wdata"}, 32'(bus_wdata), 32'h00);
  endtask

  // One Z80 I/O cycle: strobes held at least 8 clk and extended while WAIT is high.
  task automatic slot_cycle(input bit is_wr, input logic [7:0] a, input logic [7:0] d);
    bit match;
    int first;
    int wait_cnt;
    int guard;
    int exp_len;
    match    = ((a & 8'hFC) == 8'h98);
    first    = 0;
    wait_cnt = 0;
    guard    = 0;
    exp_len  = match ? (ready_lat + (is_wr ? 0 : rdata_lat) + 1) : 0;
    @(negedge clk);
    slot_a      = a;
    slot_d_in   = d;
    slot_iorq_n = 1'b0;
    if (is_wr) slot_wr_n = 1'b0;
    else slot_rd_n = 1'b0;
    if (match) exp_q.push_back(txn_t'{wr: is_wr, adr: a[1:0], data: d});
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (slot_wait) begin
        wait_cnt++;
        if (first == 0) first = i;
      end
    end
    while (slot_wait && guard < 300) begin
      @(negedge clk);
      if (slot_wait) wait_cnt++;
      guard++;
    end
    check("wait_release_in_time", 32'(guard < 300), 32'd1);
    check($sformatf("wait_latency first=%0d", first),
          32'(match ? (first >= 1 && first <= 6) : (first == 0)), 32'd1);
    check("wait_length", 32'(wait_cnt), 32'(exp_len));
    if (!is_wr && match) begin
      check("rd_data", 32'(slot_d_out), 32'(vdp_rdata));
      check("rd_oe_on", 32'(slot_d_oe), 32'd1);
    end
    if (is_wr) begin
      slot_wr_n   = 1'b1;
      slot_iorq_n = 1'b1;
      repeat (3) @(negedge clk);
    end else begin
      slot_rd_n = 1'b1;
      repeat (5) @(negedge clk);
      check("rd_oe_off_after_rd", 32'(slot_d_oe), 32'd0);
      slot_iorq_n = 1'b1;
      repeat (3) @(negedge clk);
    end
    check_scoreboard("cycle");
  endtask

  initial begin
    int         guard;
    int         hs0;
    logic [7:0] d;
    logic [7:0] a;

    reset_n     = 1'b0;
    slot_a      = 8'h00;
    slot_d_in   = 8'h00;
    slot_iorq_n = 1'b1;
    slot_rd_n   = 1'b1;
    slot_wr_n   = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two VDP register writes to port 0x99 with ready tied high.
    ready_lat = 0;
    slot_cycle(1'b1, 8'h99, 8'h00);
    slot_cycle(1'b1, 8'h99, 8'h40);

    // Long stream of writes to 0x98.
    for (int i = 0; i < 2048; i++) slot_cycle(1'b1, 8'h98, 8'(i));

    // Read from 0x9B with data returned 10 clk after ready.
    ready_lat = 0;
    rdata_lat = 10;
    vdp_rdata = 8'h5A;
    slot_cycle(1'b0, 8'h9B, 8'($urandom));

    // Out-of-window port and a 2-clk IORQ glitch.
    slot_cycle(1'b1, 8'hA0, 8'h33);
    @(negedge clk);
    slot_a      = 8'h98;
    slot_iorq_n = 1'b0;
    slot_wr_n   = 1'b0;
    repeat (2) @(negedge clk);
    slot_iorq_n = 1'b1;
    slot_wr_n   = 1'b1;
    guard = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (slot_wait || bus_valid) guard++;
    end
    check("glitch_no_activity", 32'(guard), 32'd0);
    check_scoreboard("glitch");

    // Stalled ready for 50 clk on a write to 0x9A, IORQ released meanwhile.
    ready_lat = 50;
    d = 8'($urandom);
    hs0 = hs_count;
    @(negedge clk);
    slot_a      = 8'h9A;
    slot_d_in   = d;
    slot_iorq_n = 1'b0;
    slot_wr_n   = 1'b0;
    exp_q.push_back(txn_t'{wr: 1'b1, adr: 2'b10, data: d});
    repeat (12) @(negedge clk);
    check("stall_valid_pending", 32'(bus_valid), 32'd1);
    check("stall_wait_held", 32'(slot_wait), 32'd1);
    slot_iorq_n = 1'b1;
    slot_wr_n   = 1'b1;
    guard = 0;
    while (hs_count == hs0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("stall_handshake_in_time", 32'(guard < 200), 32'd1);
    repeat (2) @(negedge clk);
    check("stall_valid_dropped", 32'(bus_valid), 32'd0);
    check("stall_wait_released", 32'(slot_wait), 32'd0);
    check("stall_valid_length", 32'(hs_len), 32'd51);
    repeat (4) @(negedge clk);
    check_scoreboard("stall");

    // Reset asserted while a read waits for data, then a normal write.
    ready_lat = 0;
    rdata_lat = 30;
    vdp_rdata = 8'($urandom);
    d = 8'($urandom);
    @(negedge clk);
    slot_a      = 8'h98;
    slot_d_in   = d;
    slot_iorq_n = 1'b0;
    slot_rd_n   = 1'b0;
    exp_q.push_back(txn_t'{wr: 1'b0, adr: 2'b00, data: d});
    repeat (12) @(negedge clk);
    check("rdwait_wait_high", 32'(slot_wait), 32'd1);
    check("rdwait_valid_low", 32'(bus_valid), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n     = 1'b1;
    slot_iorq_n = 1'b1;
    slot_rd_n   = 1'b1;
    check_reset_values("midreset");
    repeat (3) @(negedge clk);
    check_scoreboard("midreset");
    rdata_lat = 2;
    slot_cycle(1'b1, 8'h98, 8'($urandom));

    // Randomized mix of reads/writes, ports and VDP latencies.
    for (int i = 0; i < 150; i++) begin
      ready_lat = $urandom_range(0, 4);
      rdata_lat = $urandom_range(0, 6);
      vdp_rdata = 8'($urandom);
      if ($urandom_range(0, 3) == 0) a = 8'($urandom);
      else a = 8'h98 + 8'($urandom_range(0, 3));
      slot_cycle(1'($urandom_range(0, 1)), a, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
